dma_controller: RTL and testbench

- Single-channel 8-bit DMA controller with 16-bit addressing.
- The CPU programs a mode register, a byte count and a start address over a setup port.
- On DREQ it requests the bus with HLD/HLDA and moves bytes between memory and an I/O device, in single, burst or demand mode.
- It signals completion on EOP and sits between the CPU bus arbiter, system memory and one peripheral.

---
 rtl/dma_controller.sv | 133 +++++++++++++
 tb/tb_dma_controller.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/dma_controller.sv
// Single-channel 8-bit DMA controller: programmable mode/count/address, HLD/HLDA bus handshake,
// single/burst/demand transfers between memory and one I/O device.
module dma_controller #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              REGW,
    input  logic [1:0]        REGSEL,
    input  logic [ADDR_W-1:0] Setup,
    input  logic              DREQ,
    input  logic              HLDA,
    input  logic              BG,
    input  logic              RDY,
    input  logic [DATA_W-1:0] Data_in,
    output logic              HLD,
    output logic              DACK,
    output logic              MEMR,
    output logic              MEMW,
    output logic              IOR,
    output logic              IOW,
    output logic              EOP,
    output logic [ADDR_W-1:0] Addrbus,
    output logic [DATA_W-1:0] Data_out
);

    typedef enum logic [2:0] {StIdle, StReq, StAddr, StXfer, StDone} state_e;

    state_e            state_q, state_d;
    logic [7:0]        mode_q, mode_d;
    logic [ADDR_W-1:0] count_q, count_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic [ADDR_W-1:0] addrbus_q;
    logic              hld_q, dack_q, xfer_q, eop_q;

    logic mode_dir, mode_inc, mode_en, mode_burst, mode_demand;
    logic unused_mode;

    assign mode_dir    = mode_q[0];
    assign mode_inc    = mode_q[4];
    assign mode_en     = mode_q[7];
    assign mode_burst  = (mode_q[3:2] == 2'b01);
    assign mode_demand = (mode_q[3:2] == 2'b10);
    assign unused_mode = ^{mode_q[6:5], mode_q[1]};

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        count_d = count_q;
        addr_d  = addr_q;
        dout_d  = dout_q;
        unique case (state_q)
            StIdle: begin
                if (REGW) begin
                    unique case (REGSEL)
                        2'b00:   mode_d  = Setup[7:0];
                        2'b01:   count_d = Setup;
                        2'b10:   addr_d  = Setup;
                        default: ;
                    endcase
                end else if (mode_en && (count_q != '0) && DREQ) begin
                    state_d = StReq;
                end
            end
            StReq: begin
                if (HLDA) state_d = StAddr;
            end
            StAddr: begin
                if (!HLDA)   state_d = StIdle;
                else if (!BG) state_d = StXfer;
            end
            StXfer: begin
                if (!HLDA) begin
                    state_d = StIdle;
                end else if (!BG && RDY) begin
                    dout_d  = Data_in;
                    addr_d  = mode_inc ? addr_q + ADDR_W'(1) : addr_q - ADDR_W'(1);
                    count_d = count_q - ADDR_W'(1);
                    if (count_q == ADDR_W'(1)) state_d = StDone;
                    else if (mode_burst)       state_d = StAddr;
                    else if (mode_demand)      state_d = DREQ ? StAddr : StIdle;
                    else                       state_d = StIdle;
                end
            end
            StDone: begin
                mode_d[7] = 1'b0;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Bus-facing outputs are registered from the next state so they line up with the state.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= StIdle;
            mode_q    <= '0;
            count_q   <= '0;
            addr_q    <= '0;
            dout_q    <= '0;
            addrbus_q <= '0;
            hld_q     <= 1'b0;
            dack_q    <= 1'b0;
            xfer_q    <= 1'b0;
            eop_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            count_q <= count_d;
            addr_q  <= addr_d;
            dout_q  <= dout_d;
            hld_q   <= state_d inside {StReq, StAddr, StXfer};
            dack_q  <= state_d inside {StAddr, StXfer};
            xfer_q  <= (state_d == StXfer);
            eop_q   <= (state_d == StDone);
            if (state_d == StAddr) addrbus_q <= addr_d;
        end
    end

    // BG gates the strobes immediately so another master never sees them.
    assign MEMR     = xfer_q & ~BG & ~mode_dir;
    assign IOW      = xfer_q & ~BG & ~mode_dir;
    assign IOR      = xfer_q & ~BG & mode_dir;
    assign MEMW     = xfer_q & ~BG & mode_dir;
    assign HLD      = hld_q;
    assign DACK     = dack_q;
    assign EOP      = eop_q;
    assign Addrbus  = addrbus_q;
    assign Data_out = dout_q;

endmodule

// File: tb/tb_dma_controller.sv
// Directed self-checking bench for dma_controller.
module tb_dma_controller;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        REGW = 1'b0;
    logic [1:0]  REGSEL = 2'b00;
    logic [15:0] Setup = '0;
    logic        DREQ = 1'b0;
    logic        HLDA = 1'b0;
    logic        BG = 1'b0;
    logic        RDY = 1'b1;
    logic [7:0]  Data_in = '0;
    logic        HLD, DACK, MEMR, MEMW, IOR, IOW, EOP;
    logic [15:0] Addrbus;
    logic [7:0]  Data_out;

    dma_controller #(.ADDR_W(16), .DATA_W(8)) dut (
        .CLK(CLK), .RST(RST), .REGW(REGW), .REGSEL(REGSEL), .Setup(Setup),
        .DREQ(DREQ), .HLDA(HLDA), .BG(BG), .RDY(RDY), .Data_in(Data_in),
        .HLD(HLD), .DACK(DACK), .MEMR(MEMR), .MEMW(MEMW), .IOR(IOR), .IOW(IOW),
        .EOP(EOP), .Addrbus(Addrbus), .Data_out(Data_out)
    );

    always #5 CLK = ~CLK;

    int          n_checks = 0;
    int          n_fail = 0;
    int          bytes, eop_n, hld_rise, strb_cyc;
    int          wait_byte, wait_left, bg_byte, bg_left, drop_after;
    logic        hld_prev, bg_done;
    logic [3:0]  exp_strb;
    logic [7:0]  din_base;
    logic [15:0] exp_addr [8];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic wr(input logic [1:0] sel, input logic [15:0] val);
        REGW = 1'b1;
        REGSEL = sel;
        Setup = val;
        step();
        REGW = 1'b0;
    endtask

    task automatic clear_stats();
        bytes = 0; eop_n = 0; hld_rise = 0; strb_cyc = 0; hld_prev = HLD;
        wait_byte = -1; wait_left = 0; bg_byte = -1; bg_left = 0; bg_done = 1'b0;
        drop_after = -1;
    endtask

    // Bus monitor: logs each completing byte and injects wait states, BG pauses and DREQ drops.
    task automatic run(input int ncyc);
        logic [3:0] strb;
        for (int c = 0; c < ncyc; c++) begin
            step();
            strb = {MEMR, MEMW, IOR, IOW};
            if (strb != 4'b0) strb_cyc++;
            if (HLD && !hld_prev) hld_rise++;
            hld_prev = HLD;
            if (EOP) begin
                eop_n++;
                check("eop_no_strobe", 32'(strb), 32'h0);
            end
            if (bg_left > 0) begin
                check("bg_strobe_off", 32'(strb), 32'h0);
                bg_left--;
                if (bg_left == 0) BG = 1'b0;
            end else if (strb != 4'b0) begin
                if (bytes == bg_byte && !bg_done) begin
                    BG = 1'b1; RDY = 1'b0; bg_left = 2; bg_done = 1'b1;
                end else if (bytes == wait_byte && wait_left > 0) begin
                    RDY = 1'b0;
                    wait_left--;
                end else begin
                    RDY = 1'b1;
                    check("addr", 32'(Addrbus), 32'(exp_addr[bytes]));
                    check("strobe_dir", 32'(strb), 32'(exp_strb));
                    if (bytes > 0) check("data_follow", 32'(Data_out), 32'(din_base + 8'(bytes - 1)));
                    Data_in = din_base + 8'(bytes);
                    bytes++;
                    if (bytes == drop_after) DREQ = 1'b0;
                end
            end
        end
    endtask

    initial begin
        HLDA = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        check("reset_ctl", 32'({HLD, DACK, MEMR, MEMW, IOR, IOW, EOP}), 32'h0);
        check("reset_addr", 32'(Addrbus), 32'h0);
        check("reset_data", 32'(Data_out), 32'h0);
        RST = 1'b1;
        DREQ = 1'b1;
        clear_stats();
        run(5);
        check("post_reset_no_hld", 32'(hld_rise), 32'd0);

        // Burst, mem->IO, increment.
        DREQ = 1'b0;
        wr(2'b00, 16'h0094); wr(2'b01, 16'h0003); wr(2'b10, 16'h0001);
        DREQ = 1'b1; RDY = 1'b1;
        step();
        check("req_hld", 32'(HLD), 32'd1);
        check("req_dack", 32'(DACK), 32'd0);
        step();
        check("addr_dack", 32'(DACK), 32'd1);
        check("addr_bus", 32'(Addrbus), 32'h1);
        check("addr_no_strobe", 32'({MEMR, MEMW, IOR, IOW}), 32'h0);
        clear_stats();
        exp_addr[0] = 16'h0001; exp_addr[1] = 16'h0002; exp_addr[2] = 16'h0003;
        exp_strb = 4'b1001; din_base = 8'hA0;
        run(20);
        check("burst_bytes", 32'(bytes), 32'd3);
        check("burst_strb_cyc", 32'(strb_cyc), 32'd3);
        check("burst_eop", 32'(eop_n), 32'd1);
        check("burst_hld_off", 32'(HLD), 32'd0);
        check("burst_dout", 32'(Data_out), 32'hA2);

        // Same setup with three wait states on the second byte.
        DREQ = 1'b0;
        wr(2'b00, 16'h0094); wr(2'b01, 16'h0003); wr(2'b10, 16'h0001);
        clear_stats();
        wait_byte = 1; wait_left = 3; din_base = 8'h50;
        DREQ = 1'b1;
        run(30);
        check("wait_bytes", 32'(bytes), 32'd3);
        check("wait_strb_cyc", 32'(strb_cyc), 32'd6);
        check("wait_eop", 32'(eop_n), 32'd1);

        // Single, IO->mem, decrement with wrap.
        DREQ = 1'b0;
        wr(2'b00, 16'h0081); wr(2'b01, 16'h0002); wr(2'b10, 16'h0000);
        clear_stats();
        exp_addr[0] = 16'h0000; exp_addr[1] = 16'hFFFF;
        exp_strb = 4'b0110; din_base = 8'h30;
        DREQ = 1'b1;
        run(30);
        check("single_bytes", 32'(bytes), 32'd2);
        check("single_hld_rises", 32'(hld_rise), 32'd2);
        check("single_eop", 32'(eop_n), 32'd1);

        // Demand, DREQ dropped after the first byte.
        DREQ = 1'b0;
        wr(2'b00, 16'h0098); wr(2'b01, 16'h0003); wr(2'b10, 16'h0010);
        clear_stats();
        exp_addr[0] = 16'h0010; exp_addr[1] = 16'h0011; exp_addr[2] = 16'h0012;
        exp_strb = 4'b1001; din_base = 8'h70; drop_after = 1;
        DREQ = 1'b1;
        run(15);
        check("demand_pause_bytes", 32'(bytes), 32'd1);
        check("demand_pause_hld", 32'(HLD), 32'd0);
        check("demand_pause_eop", 32'(eop_n), 32'd0);
        drop_after = -1;
        DREQ = 1'b1;
        run(20);
        check("demand_bytes", 32'(bytes), 32'd3);
        check("demand_eop", 32'(eop_n), 32'd1);

        // Burst with a BG pause on the first byte.
        DREQ = 1'b0;
        wr(2'b00, 16'h0094); wr(2'b01, 16'h0002); wr(2'b10, 16'h0030);
        clear_stats();
        exp_addr[0] = 16'h0030; exp_addr[1] = 16'h0031; din_base = 8'h10; bg_byte = 0;
        DREQ = 1'b1;
        run(25);
        check("bg_bytes", 32'(bytes), 32'd2);
        check("bg_eop", 32'(eop_n), 32'd1);

        // Enable was cleared by DONE: a fresh count alone must not start a transfer.
        DREQ = 1'b0;
        wr(2'b01, 16'h0002);
        clear_stats();
        DREQ = 1'b1;
        run(10);
        check("enable_cleared", 32'(hld_rise), 32'd0);

        // Count zero never requests.
        DREQ = 1'b0;
        wr(2'b00, 16'h0094); wr(2'b01, 16'h0000);
        clear_stats();
        DREQ = 1'b1;
        run(10);
        check("count_zero", 32'(hld_rise), 32'd0);

        // Register write during a transfer is ignored.
        DREQ = 1'b0;
        wr(2'b01, 16'h0002); wr(2'b10, 16'h0020);
        DREQ = 1'b1;
        step();
        REGW = 1'b1; REGSEL = 2'b10; Setup = 16'h5555;
        step();
        REGW = 1'b0;
        check("regw_ignored_addr", 32'(Addrbus), 32'h0020);
        clear_stats();
        exp_addr[0] = 16'h0020; exp_addr[1] = 16'h0021; din_base = 8'hC0;
        run(20);
        check("regw_ignored_bytes", 32'(bytes), 32'd2);
        check("regw_ignored_eop", 32'(eop_n), 32'd1);

        // Reset mid-transfer.
        DREQ = 1'b0;
        wr(2'b00, 16'h0094); wr(2'b01, 16'h0004); wr(2'b10, 16'h0040);
        DREQ = 1'b1;
        repeat (3) step();
        check("midxfer_strobe", 32'({MEMR, IOW}), 32'h3);
        RST = 1'b0;
        #1;
        check("midrst_ctl", 32'({HLD, DACK, MEMR, MEMW, IOR, IOW, EOP}), 32'h0);
        check("midrst_addr", 32'(Addrbus), 32'h0);
        check("midrst_data", 32'(Data_out), 32'h0);
        #3;
        RST = 1'b1;
        clear_stats();
        run(5);
        check("midrst_regs_clear", 32'(hld_rise), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
